// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_sb                                                      |
// | Brief    : Register file with write bypass and per-register pending-write  |
// |            scoreboard that stalls decode on unresolved source operands.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module regfile_sb #(
  parameter int DW      = 32,
  parameter int AW      = 4,
  parameter int PW      = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DW-1:0]    wb_data,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [DW-1:0]    ra_data,
  output logic [DW-1:0]    rb_data,
  input  logic             iss_valid,
  input  logic             iss_use_a,
  input  logic             iss_use_b,
  input  logic             iss_wr,
  input  logic [AW-1:0]    iss_dest,
  output logic             stall,
  output logic [2**AW-1:0] busy_vec,
  output logic             sb_err
);

  localparam int            NREGS     = 2**AW;
  localparam bit            c_zero_r0 = (ZERO_R0 != 0);
  localparam logic [PW-1:0] c_cnt_one = PW'(1);
  localparam logic [PW-1:0] c_cnt_max = '1;

  logic [DW-1:0] r_regs [NREGS];
  logic [PW-1:0] r_cnt  [NREGS];
  logic          r_err;

  logic             w_wb_live;
  logic             w_busy_a;
  logic             w_busy_b;
  logic             w_sat;
  logic             w_acc;
  logic             w_underflow;
  logic [NREGS-1:0] w_we;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;

  // A writeback to a hardwired R0 is discarded entirely.
  assign w_wb_live = wb_en && !(c_zero_r0 && (wb_addr == '0));

  always_comb begin
    ra_data = r_regs[ra_addr];
    if (w_wb_live && (wb_addr == ra_addr)) ra_data = wb_data;
    if (c_zero_r0 && (ra_addr == '0))      ra_data = '0;
  end

  always_comb begin
    rb_data = r_regs[rb_addr];
    if (w_wb_live && (wb_addr == rb_addr)) rb_data = wb_data;
    if (c_zero_r0 && (rb_addr == '0))      rb_data = '0;
  end

  // The final pending write landing this cycle is served by the bypass.
  assign w_busy_a = (r_cnt[ra_addr] != '0) &&
                    !(wb_en && (wb_addr == ra_addr) && (r_cnt[ra_addr] == c_cnt_one));
  assign w_busy_b = (r_cnt[rb_addr] != '0) &&
                    !(wb_en && (wb_addr == rb_addr) && (r_cnt[rb_addr] == c_cnt_one));
  assign w_sat    = (r_cnt[iss_dest] == c_cnt_max);

  assign stall = iss_valid && ((iss_use_a && w_busy_a) ||
                               (iss_use_b && w_busy_b) ||
                               (iss_wr && w_sat));
  assign w_acc = iss_valid && !stall;

  assign w_underflow = w_wb_live && (r_cnt[wb_addr] == '0);

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_ctl
      localparam bit c_tied = c_zero_r0 && (gi == 0);
      assign w_we[gi]     = !c_tied && wb_en && (wb_addr == AW'(gi));
      assign w_inc[gi]    = !c_tied && w_acc && iss_wr && (iss_dest == AW'(gi));
      assign w_dec[gi]    = w_we[gi] && (r_cnt[gi] != '0);
      assign busy_vec[gi] = (r_cnt[gi] != '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_we[i]) r_regs[i] <= wb_data;
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + c_cnt_one;
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_err <= 1'b0;
    else if (w_underflow) r_err <= 1'b1;
  end

  assign sb_err = r_err;

endmodule
`default_nettype wire
